// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word-class encoding, alignment FSM states,
// control / TERC4 / guard-band codewords (all in wire bit order, bit 0 is
// the first bit on the wire) and the 10-bit decode function used by every
// channel.
package tmds_pkg;

    typedef enum logic [1:0] {
        KIND_VIDEO = 2'd0,
        KIND_CTRL  = 2'd1,
        KIND_TERC4 = 2'd2,
        KIND_GUARD = 2'd3
    } kind_t;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } align_state_t;

    localparam logic [9:0] CTRL_0 = 10'h0AB;
    localparam logic [9:0] CTRL_1 = 10'h354;
    localparam logic [9:0] CTRL_2 = 10'h0AA;
    localparam logic [9:0] CTRL_3 = 10'h355;

    // Video guard-band word (the one that does not alias a TERC4 code).
    localparam logic [9:0] GUARD_VIDEO = 10'h332;

    // TERC4 codewords; element i decodes to nibble i.
    localparam logic [15:0][9:0] TERC4_CODE = {
        10'h30D, 10'h31A, 10'h239, 10'h1C5,   // 15..12
        10'h18D, 10'h0E6, 10'h272, 10'h0CD,   // 11..8
        10'h0F2, 10'h1C6, 10'h1E2, 10'h23A,   //  7..4
        10'h11D, 10'h09D, 10'h319, 10'h0E5    //  3..0
    };

    typedef struct packed {
        logic [7:0] pix;
        logic [1:0] ctl;
        logic [3:0] aux;
        kind_t      kind;
    } decode_t;

    // Full decode of one aligned word. The video byte is produced for every
    // word; class, control pair and TERC4 nibble come from codeword lookup.
    function automatic decode_t tmds_decode(input logic [9:0] w);
        decode_t    r;
        logic [7:0] d;
        d        = w[9] ? ~w[7:0] : w[7:0];
        r.pix    = '0;
        r.pix[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            r.pix[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        r.ctl  = 2'd0;
        r.aux  = 4'd0;
        r.kind = KIND_VIDEO;
        case (w)
            CTRL_0:      begin r.kind = KIND_CTRL; r.ctl = 2'd0; end
            CTRL_1:      begin r.kind = KIND_CTRL; r.ctl = 2'd1; end
            CTRL_2:      begin r.kind = KIND_CTRL; r.ctl = 2'd2; end
            CTRL_3:      begin r.kind = KIND_CTRL; r.ctl = 2'd3; end
            GUARD_VIDEO: r.kind = KIND_GUARD;
            default:     ;
        endcase
        for (int i = 0; i < 16; i++) begin
            if (w == TERC4_CODE[4'(i)]) begin
                r.kind = KIND_TERC4;
                r.aux  = 4'(i);
                r.ctl  = 2'(i);
            end
        end
        return r;
    endfunction

    // Bit-slip offsets run 0..9 and wrap.
    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off == 4'd9) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_chan_align.sv
// One TMDS channel: bit-slip window, SEARCH/LOCKED word-alignment FSM and
// registered decode of the aligned word.
//   i_clk, i_reset_n : pixel clock, asynchronous active-low reset
//   i_word           : raw 10-bit word, arbitrary bit alignment
//   i_resync         : drop lock / restart search
//   o_pix/o_ctl/o_aux/o_kind : registered decode of the aligned word
//   o_lock           : high while the FSM is LOCKED
//   o_offset         : current bit-slip offset 0..9
module tmds_chan_align
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 64,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [9:0] i_word,
    input  logic       i_resync,
    output logic [7:0] o_pix,
    output logic [1:0] o_ctl,
    output logic [3:0] o_aux,
    output logic [1:0] o_kind,
    output logic       o_lock,
    output logic [3:0] o_offset
);

    localparam int HIT_W   = $clog2(LOCK_COUNT + 1);
    localparam int DWELL_W = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int LOSS_W  = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

    localparam logic [HIT_W-1:0]   HIT_LIMIT  = HIT_W'(LOCK_COUNT);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_TIMEOUT - 1);

    logic [9:0]         prev;
    logic [19:0]        window;
    logic [9:0]         aligned;
    decode_t            dec;
    logic               is_ctrl;
    align_state_t       state;
    logic [3:0]         offset;
    logic [HIT_W-1:0]   hit_cnt;
    logic [DWELL_W-1:0] dwell;
    logic [LOSS_W-1:0]  loss_cnt;

    // Current word above the previous one, so any 10-bit slice starting at
    // 0..9 is a complete candidate word.
    assign window   = {i_word, prev};
    assign aligned  = window[offset +: 10];
    assign dec      = tmds_decode(aligned);
    assign is_ctrl  = (dec.kind == KIND_CTRL);
    assign o_offset = offset;

    // NOTE: non-blocking assignments make every register sample pre-edge values,
    // so the order of statements across always_ff blocks cannot matter.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prev   <= '0;
            o_pix  <= '0;
            o_ctl  <= '0;
            o_aux  <= '0;
            o_kind <= '0;
        end else begin
            prev   <= i_word;
            o_pix  <= dec.pix;
            o_ctl  <= dec.ctl;
            o_aux  <= dec.aux;
            o_kind <= dec.kind;
        end
    end

    // Every counter either transitions or clears before reaching its limit,
    // so none can wrap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_SEARCH;
            o_lock   <= 1'b0;
            offset   <= '0;
            hit_cnt  <= '0;
            dwell    <= '0;
            loss_cnt <= '0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (i_resync) begin
                        hit_cnt <= '0;
                        dwell   <= '0;
                    end else if (hit_cnt == HIT_LIMIT) begin
                        // Lock has priority over a coincident dwell timeout.
                        state    <= ST_LOCKED;
                        o_lock   <= 1'b1;
                        hit_cnt  <= '0;
                        dwell    <= '0;
                        loss_cnt <= '0;
                    end else if (dwell == DWELL_LAST) begin
                        offset  <= next_offset(offset);
                        hit_cnt <= '0;
                        dwell   <= '0;
                    end else begin
                        dwell   <= dwell + 1'b1;
                        hit_cnt <= is_ctrl ? hit_cnt + 1'b1 : '0;
                    end
                end
                ST_LOCKED: begin
                    if (i_resync || (!is_ctrl && loss_cnt == LOSS_LAST)) begin
                        state    <= ST_SEARCH;
                        o_lock   <= 1'b0;
                        offset   <= next_offset(offset);
                        hit_cnt  <= '0;
                        dwell    <= '0;
                        loss_cnt <= '0;
                    end else begin
                        loss_cnt <= is_ctrl ? '0 : loss_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_SEARCH;
                    o_lock <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tmds_align_decode.sv
// Multi-channel TMDS word aligner and decoder.
//   i_clk, i_reset_n : pixel clock, asynchronous active-low reset
//   i_word           : NCH raw 10-bit words, channel c at [10c+9:10c]
//   i_resync         : drop lock on all channels and restart search
//   o_pix/o_ctl/o_aux/o_kind : per-channel decode (8/2/4/2 bits each)
//   o_lock           : per-channel word lock
//   o_all_lock       : registered AND of o_lock
//   o_offset         : per-channel bit-slip offset (4 bits each)
module tmds_align_decode
    import tmds_pkg::*;
#(
    parameter int NCH            = 3,
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 64,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [10*NCH-1:0] i_word,
    input  logic              i_resync,
    output logic [8*NCH-1:0]  o_pix,
    output logic [2*NCH-1:0]  o_ctl,
    output logic [4*NCH-1:0]  o_aux,
    output logic [2*NCH-1:0]  o_kind,
    output logic [NCH-1:0]    o_lock,
    output logic              o_all_lock,
    output logic [4*NCH-1:0]  o_offset
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        tmds_chan_align #(
            .LOCK_COUNT     (LOCK_COUNT),
            .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
            .LOSS_TIMEOUT   (LOSS_TIMEOUT)
        ) u_chan (
            .i_clk    (i_clk),
            .i_reset_n(i_reset_n),
            .i_word   (i_word[10*c +: 10]),
            .i_resync (i_resync),
            .o_pix    (o_pix[8*c +: 8]),
            .o_ctl    (o_ctl[2*c +: 2]),
            .o_aux    (o_aux[4*c +: 4]),
            .o_kind   (o_kind[2*c +: 2]),
            .o_lock   (o_lock[c]),
            .o_offset (o_offset[4*c +: 4])
        );
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_all_lock <= 1'b0;
        end else begin
            o_all_lock <= &o_lock;
        end
    end

endmodule

// File: tb/tb_tmds_align_decode.sv
// Self-checking bench for tmds_align_decode (NCH=4, shortened timeouts).
// Inputs change on the falling edge; outputs are observed on the falling
// edge before new stimulus is applied.
module tb_tmds_align_decode;

    localparam int NCH = 4;
    localparam int LC  = 8;
    localparam int ST  = 32;
    localparam int LT  = 256;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [10*NCH-1:0] word = '0;
    logic              resync = 1'b0;
    logic [8*NCH-1:0]  pix;
    logic [2*NCH-1:0]  ctl;
    logic [4*NCH-1:0]  aux;
    logic [2*NCH-1:0]  kind;
    logic [NCH-1:0]    lock;
    logic              all_lock;
    logic [4*NCH-1:0]  offset;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tmds_align_decode #(
        .NCH(NCH), .LOCK_COUNT(LC), .SEARCH_TIMEOUT(ST), .LOSS_TIMEOUT(LT)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_word(word), .i_resync(resync),
        .o_pix(pix), .o_ctl(ctl), .o_aux(aux), .o_kind(kind),
        .o_lock(lock), .o_all_lock(all_lock), .o_offset(offset)
    );

    // Codeword tables as printed in the standards: leftmost character is
    // the first bit on the wire.
    logic [9:0] terc4_str [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    logic [9:0] guard_str = 10'b0100110011;
    logic [9:0] ctrl_tok [4] = '{10'h0AB, 10'h354, 10'h0AA, 10'h355};

    typedef struct {
        logic [7:0] pix;
        logic [1:0] ctl;
        logic [3:0] aux;
        logic [1:0] kind;
    } ref_t;

    function automatic logic [9:0] wire_order(input logic [9:0] s);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = s[9-i];
        return r;
    endfunction

    function automatic logic [9:0] rotl10(input logic [9:0] w, input int n);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[(i + n) % 10] = w[i];
        return r;
    endfunction

    // Reference decode from the codeword tables and the TMDS video rule.
    function automatic ref_t ref_decode(input logic [9:0] w);
        ref_t       r;
        logic [7:0] d;
        logic       x;
        d = w[9] ? ~w[7:0] : w[7:0];
        r.pix = 8'd0;
        r.pix[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            x = d[i] ^ d[i-1];
            r.pix[i] = w[8] ? x : ~x;
        end
        r.ctl = 2'd0; r.aux = 4'd0; r.kind = 2'd0;
        for (int k = 0; k < 4; k++)
            if (w == ctrl_tok[k]) begin r.kind = 2'd1; r.ctl = 2'(k); end
        for (int k = 0; k < 16; k++)
            if (w == wire_order(terc4_str[k])) begin
                r.kind = 2'd2; r.aux = 4'(k); r.ctl = 2'(k);
            end
        if (w == wire_order(guard_str)) r.kind = 2'd3;
        return r;
    endfunction

    task automatic apply_reset(input logic [10*NCH-1:0] w);
        reset_n = 1'b0;
        resync  = 1'b0;
        word    = w;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({pix, ctl, aux, kind} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {pix, ctl, aux, kind});
        end
        n_tests++;
        if ({lock, all_lock, offset} !== '0) begin
            n_fail++;
            $display("FAIL reset_lock: got %h expected 0", {lock, all_lock, offset});
        end
    endtask

    task automatic test_ctrl_lock;
        apply_reset({NCH{10'h354}});
        repeat (LC + 1) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (lock !== '0) begin
            n_fail++;
            $display("FAIL early_lock: got %b expected 0", lock);
        end
        @(negedge clk);
        n_tests++;
        if (lock !== '1) begin
            n_fail++;
            $display("FAIL ctrl_lock: got %b expected all 1", lock);
        end
        n_tests++;
        if (ctl !== {NCH{2'd1}} || kind !== {NCH{2'd1}}) begin
            n_fail++;
            $display("FAIL ctrl_decode: got ctl %h kind %h expected 55 55", ctl, kind);
        end
        n_tests++;
        if (offset !== '0) begin
            n_fail++;
            $display("FAIL ctrl_offset: got %h expected 0", offset);
        end
        @(negedge clk);
        n_tests++;
        if (all_lock !== 1'b1) begin
            n_fail++;
            $display("FAIL ctrl_all_lock: got %b expected 1", all_lock);
        end
    endtask

    // Random mix of video, control, TERC4 and guard words while locked at
    // offset 0; each output is the decode of the word driven two cycles ago.
    task automatic test_random_decode;
        logic [10*NCH-1:0] p1, p2, w;
        logic [8*NCH-1:0]  e_pix;
        logic [2*NCH-1:0]  e_ctl, e_kind;
        logic [4*NCH-1:0]  e_aux;
        logic [9:0]        cw;
        ref_t              r;
        p1 = word;
        p2 = word;
        repeat (120) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                r = ref_decode(p2[10*c +: 10]);
                e_pix[8*c +: 8]  = r.pix;
                e_ctl[2*c +: 2]  = r.ctl;
                e_aux[4*c +: 4]  = r.aux;
                e_kind[2*c +: 2] = r.kind;
            end
            n_tests++;
            if (pix !== e_pix) begin
                n_fail++;
                $display("FAIL rnd_pix: got %h expected %h (in %h)", pix, e_pix, p2);
            end
            n_tests++;
            if (kind !== e_kind) begin
                n_fail++;
                $display("FAIL rnd_kind: got %h expected %h (in %h)", kind, e_kind, p2);
            end
            n_tests++;
            if (ctl !== e_ctl || aux !== e_aux) begin
                n_fail++;
                $display("FAIL rnd_ctl_aux: got %h/%h expected %h/%h", ctl, aux, e_ctl, e_aux);
            end
            n_tests++;
            if (all_lock !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_lock_hold: got %b expected 1", all_lock);
            end
            for (int c = 0; c < NCH; c++) begin
                case ($urandom_range(0, 3))
                    0: cw = 10'($urandom);
                    1: cw = ctrl_tok[$urandom_range(0, 3)];
                    2: cw = wire_order(terc4_str[$urandom_range(0, 15)]);
                    default: cw = wire_order(guard_str);
                endcase
                w[10*c +: 10] = cw;
            end
            p2 = p1;
            p1 = w;
            word = w;
        end
    endtask

    task automatic test_terc4_guard;
        logic [9:0] cw;
        int         idx;
        for (int j = 0; j < 19; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                idx = j - 2;
                n_tests++;
                if (idx < 16) begin
                    if (kind !== {NCH{2'd2}} || aux !== {NCH{4'(idx)}} || ctl !== {NCH{2'(idx)}}) begin
                        n_fail++;
                        $display("FAIL terc4_%0d: got kind %h aux %h ctl %h expected kind 2 aux %0d",
                                 idx, kind, aux, ctl, idx);
                    end
                end else begin
                    if (kind !== {NCH{2'd3}} || aux !== '0 || ctl !== '0) begin
                        n_fail++;
                        $display("FAIL guard: got kind %h aux %h ctl %h expected kind 3 aux 0 ctl 0",
                                 kind, aux, ctl);
                    end
                end
            end
            if (j < 17) begin
                cw = (j < 16) ? wire_order(terc4_str[j]) : wire_order(guard_str);
                word = {NCH{cw}};
            end
        end
    endtask

    task automatic test_video_loss;
        ref_t r;
        bit   fell;
        word = {NCH{10'h354}};
        repeat (4) @(negedge clk);
        word = {NCH{10'h1FF}};
        repeat (2) @(negedge clk);
        r = ref_decode(10'h1FF);
        n_tests++;
        if (pix !== {NCH{r.pix}} || kind !== '0) begin
            n_fail++;
            $display("FAIL video_1ff: got pix %h kind %h expected %h 0", pix, kind, {NCH{r.pix}});
        end
        repeat (LT - 3) @(negedge clk);
        n_tests++;
        if (lock !== '1) begin
            n_fail++;
            $display("FAIL loss_early: got %b expected all 1", lock);
        end
        fell = 1'b0;
        for (int i = 0; i < 8 && !fell; i++) begin
            @(negedge clk);
            if (lock === '0) fell = 1'b1;
        end
        n_tests++;
        if (!fell) begin
            n_fail++;
            $display("FAIL loss_timeout: got lock %b expected 0 within bound", lock);
        end
        n_tests++;
        if (offset !== {NCH{4'd1}}) begin
            n_fail++;
            $display("FAIL loss_offset: got %h expected %h", offset, {NCH{4'd1}});
        end
    endtask

    task automatic test_resync;
        bit got;
        apply_reset({NCH{10'h354}});
        got = 1'b0;
        for (int i = 0; i < LC + 10 && !got; i++) begin
            @(negedge clk);
            if (lock === '1) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL resync_prelock: got %b expected all 1", lock);
        end
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        n_tests++;
        if (lock !== '0 || offset !== {NCH{4'd1}}) begin
            n_fail++;
            $display("FAIL resync_locked: got lock %b off %h expected 0 %h", lock, offset, {NCH{4'd1}});
        end
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        n_tests++;
        if (lock !== '0 || offset !== {NCH{4'd1}}) begin
            n_fail++;
            $display("FAIL resync_search: got lock %b off %h expected 0 %h", lock, offset, {NCH{4'd1}});
        end
    endtask

    task automatic test_rotated_lock;
        bit got;
        apply_reset({NCH{rotl10(10'h0AB, 3)}});
        got = 1'b0;
        for (int i = 0; i < 4 * ST + LC + 2 && !got; i++) begin
            @(negedge clk);
            if (lock === '1) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL rot_lock: got %b expected all 1 within bound", lock);
        end
        n_tests++;
        if (offset !== {NCH{4'd3}}) begin
            n_fail++;
            $display("FAIL rot_offset: got %h expected %h", offset, {NCH{4'd3}});
        end
    endtask

    task automatic test_multi_offset;
        int                base;
        int                offs [NCH];
        logic [10*NCH-1:0] w;
        logic [4*NCH-1:0]  e_off;
        logic [NCH-1:0]    prev_lock;
        bit                got;
        base = $urandom_range(0, 9);
        for (int c = 0; c < NCH; c++) begin
            offs[c] = (base + 3 * c) % 10;
            w[10*c +: 10] = rotl10((c % 2 == 0) ? 10'h0AB : 10'h354, offs[c]);
            e_off[4*c +: 4] = 4'(offs[c]);
        end
        apply_reset(w);
        prev_lock = '0;
        got = 1'b0;
        for (int i = 0; i < 10 * ST + LC + 10 && !got; i++) begin
            @(negedge clk);
            n_tests++;
            if (all_lock !== (&prev_lock)) begin
                n_fail++;
                $display("FAIL all_lock_and: got %b expected %b (prev lock %b)", all_lock, &prev_lock, prev_lock);
            end
            if (all_lock === 1'b1) got = 1'b1;
            prev_lock = lock;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL multi_lock: got lock %b expected all_lock within bound", lock);
        end
        n_tests++;
        if (offset !== e_off) begin
            n_fail++;
            $display("FAIL multi_offset: got %h expected %h", offset, e_off);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({pix, ctl, aux, kind, lock, all_lock, offset} !== '0) begin
            n_fail++;
            $display("FAIL midlock_reset: got %h expected 0",
                     {pix, ctl, aux, kind, lock, all_lock, offset});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ctrl_lock();
        test_random_decode();
        test_terc4_guard();
        test_video_loss();
        test_resync();
        test_rotated_lock();
        test_multi_offset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
